// File: rtl/pr5_seq_detector.sv
// Serial 1-0-1 recogniser with overlap.
// Two-bit Moore FSM whose state bits are exported directly.
module pr5_seq_detector (
  input  logic clock,
  input  logic reset,
  input  logic X,
  output logic Aplus,
  output logic Bplus,
  output logic Z
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  logic [1:0] r_state;
  logic [1:0] w_next;

  // S3 falls back to S1/S2 so a trailing "1" or "10" starts the next match
  always_comb begin
    w_next = S0;
    case (r_state)
      S0: w_next = X ? S1 : S0;
      S1: w_next = X ? S1 : S2;
      S2: w_next = X ? S3 : S0;
      S3: w_next = X ? S1 : S2;
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  assign Aplus = r_state[1];
  assign Bplus = r_state[0];
  assign Z     = r_state[1] & r_state[0];

endmodule

// File: tb/tb_pr5_seq_detector.sv
// Bench for pr5_seq_detector: directed sequences plus
// random stream checked against a suffix-matching model.
module tb_pr5_seq_detector;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic X = 1'b0;
  logic Aplus;
  logic Bplus;
  logic Z;

  int vectors = 0;
  int errors = 0;
  bit hist[$];

  pr5_seq_detector dut (
    .clock(clock),
    .reset(reset),
    .X(X),
    .Aplus(Aplus),
    .Bplus(Bplus),
    .Z(Z)
  );

  always #5 clock = ~clock;

  // progress toward "101" = longest suffix of history that is a prefix
  function automatic logic [1:0] ref_state();
    int n = hist.size();
    if (n >= 3 && hist[n-3] && !hist[n-2] && hist[n-1])
      return 2'b11;
    if (n >= 2 && hist[n-2] && !hist[n-1])
      return 2'b10;
    if (n >= 1 && hist[n-1])
      return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input bit x, input bit rst);
    @(negedge clock);
    X = x;
    reset = rst;
    @(posedge clock);
    if (rst) hist.delete();
    else hist.push_back(x);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step($urandom_range(0, 1), 1'b1);
      vectors++;
      if ({Aplus, Bplus} !== 2'b00) begin
        errors++;
        $display("FAIL reset_state edge %0d: got %b want 00",
                 i, {Aplus, Bplus});
      end
      vectors++;
      if (Z !== 1'b0) begin
        errors++;
        $display("FAIL reset_z edge %0d: got %b want 0", i, Z);
      end
    end
  endtask

  task automatic run_seq(input string name, input bit xs[],
                         input logic [1:0] st[], input bit zs[]);
    step(1'b0, 1'b1);
    for (int i = 0; i < xs.size(); i++) begin
      step(xs[i], 1'b0);
      vectors++;
      if ({Aplus, Bplus} !== st[i]) begin
        errors++;
        $display("FAIL %s_state edge %0d: got %b want %b",
                 name, i + 1, {Aplus, Bplus}, st[i]);
      end
      vectors++;
      if (Z !== zs[i]) begin
        errors++;
        $display("FAIL %s_z edge %0d: got %b want %b",
                 name, i + 1, Z, zs[i]);
      end
    end
  endtask

  task automatic test_basic();
    bit xs[] = '{1, 0, 1};
    logic [1:0] st[] = '{2'b01, 2'b10, 2'b11};
    bit zs[] = '{0, 0, 1};
    run_seq("basic", xs, st, zs);
  endtask

  task automatic test_overlap();
    bit xs[] = '{1, 0, 1, 0, 1};
    logic [1:0] st[] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
    bit zs[] = '{0, 0, 1, 0, 1};
    run_seq("overlap", xs, st, zs);
  endtask

  task automatic test_no_match();
    bit xs[] = '{1, 1, 0, 0, 1};
    logic [1:0] st[] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
    bit zs[] = '{0, 0, 0, 0, 0};
    run_seq("nomatch", xs, st, zs);
  endtask

  task automatic test_reset_mid();
    bit xs[] = '{1, 0};
    logic [1:0] st[] = '{2'b01, 2'b10};
    bit zs[] = '{0, 0};
    run_seq("midpre", xs, st, zs);
    step(1'b1, 1'b1);
    vectors++;
    if ({Aplus, Bplus, Z} !== 3'b000) begin
      errors++;
      $display("FAIL midreset: got %b want 000",
               {Aplus, Bplus, Z});
    end
    step(1'b1, 1'b0);
    vectors++;
    if ({Aplus, Bplus, Z} !== 3'b010) begin
      errors++;
      $display("FAIL midreset_after: got %b want 010",
               {Aplus, Bplus, Z});
    end
  endtask

  task automatic test_random();
    logic [1:0] exp;
    step(1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 1), 1'b0);
      exp = ref_state();
      vectors++;
      if ({Aplus, Bplus} !== exp) begin
        errors++;
        $display("FAIL rand_state edge %0d: got %b want %b",
                 i, {Aplus, Bplus}, exp);
      end
      vectors++;
      if (Z !== (exp == 2'b11)) begin
        errors++;
        $display("FAIL rand_z edge %0d: got %b want %b",
                 i, Z, (exp == 2'b11));
      end
      vectors++;
      if (Z !== (Aplus & Bplus)) begin
        errors++;
        $display("FAIL rand_zdec edge %0d: got %b want %b",
                 i, Z, Aplus & Bplus);
      end
      // mid-cycle wiggle on X must not disturb state
      X = $urandom_range(0, 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_no_match();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
